dcim_macro_driver: RTL and testbench

DCIM_MACRO_DRIVER -- requirements
Module: dcim_macro_driver

---
 rtl/dcim_macro_driver.sv | 194 +++++++++++++++++++
 tb/tb_dcim_macro_driver.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dcim_macro_driver.sv
// Host-side driver for a digital compute-in-memory macro: sequences weight writes and
// compute requests, watches the macro done flag with a timeout, and returns one result per compute.
module dcim_macro_driver #(
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic         cmd_op,
  input  logic [2:0]   cmd_row,
  input  logic [23:0]  cmd_data,
  input  logic [191:0] cmd_xin,
  input  logic         cmd_inwidth,
  input  logic         cmd_wwidth,
  output logic [23:0]  m_D,
  output logic [7:0]   m_WA,
  output logic         m_acm_en,
  output logic         m_cima,
  output logic         m_start,
  output logic         m_inwidth,
  output logic         m_wwidth,
  output logic [191:0] m_xin0,
  input  logic [50:0]  m_nout,
  input  logic         m_st,
  output logic         res_valid,
  input  logic         res_ready,
  output logic [50:0]  res_data,
  output logic         res_err
);

  localparam int unsigned ROW_W  = 3;
  localparam int unsigned DATA_W = 24;
  localparam int unsigned WA_W   = 8;
  localparam int unsigned XIN_W  = 192;
  localparam int unsigned RES_W  = 51;
  localparam int unsigned CNT_W  = 16;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    GAP   = 3'd2,
    SETUP = 3'd3,
    START = 3'd4,
    WAIT  = 3'd5,
    RESP  = 3'd6
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ROW_W-1:0]   row_q, row_d;
  logic [DATA_W-1:0]  data_q, data_d;
  logic [XIN_W-1:0]   xin_q, xin_d;
  logic               inw_q, inw_d;
  logic               ww_q, ww_d;

  logic               cmd_ready_q, cmd_ready_d;
  logic [DATA_W-1:0]  m_d_q, m_d_d;
  logic [WA_W-1:0]    m_wa_q, m_wa_d;
  logic               m_acm_en_q;
  logic               m_cima_q, m_cima_d;
  logic               m_start_q, m_start_d;
  logic               m_inw_q, m_inw_d;
  logic               m_ww_q, m_ww_d;
  logic [XIN_W-1:0]   m_xin_q, m_xin_d;
  logic               res_valid_q, res_valid_d;
  logic [RES_W-1:0]   res_data_q, res_data_d;
  logic               res_err_q, res_err_d;

  logic               hs;
  logic               in_cim;

  // Next state, captured command, and output values decoded from the next state
  always_comb begin
    state_d    = state_q;
    cnt_d      = '0;
    row_d      = row_q;
    data_d     = data_q;
    xin_d      = xin_q;
    inw_d      = inw_q;
    ww_d       = ww_q;
    res_data_d = res_data_q;
    res_err_d  = res_err_q;
    hs         = cmd_valid && cmd_ready_q;

    unique case (state_q)
      IDLE: begin
        if (hs) begin
          row_d   = cmd_row;
          data_d  = cmd_data;
          xin_d   = cmd_xin;
          inw_d   = cmd_inwidth;
          ww_d    = cmd_wwidth;
          state_d = cmd_op ? SETUP : WR;
        end
      end
      WR:    state_d = GAP;
      GAP:   state_d = IDLE;
      SETUP: state_d = START;
      START: state_d = WAIT;
      WAIT: begin
        // A done flag on the final allowed cycle still counts as a normal completion
        if (m_st) begin
          res_data_d = m_nout;
          res_err_d  = 1'b0;
          state_d    = RESP;
        end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
          res_data_d = '0;
          res_err_d  = 1'b1;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP: begin
        if (res_ready) begin
          res_data_d = '0;
          res_err_d  = 1'b0;
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    in_cim      = (state_d == SETUP) || (state_d == START) || (state_d == WAIT);
    cmd_ready_d = (state_d == IDLE);
    m_wa_d      = (state_d == WR) ? (WA_W'(1) << row_d) : '0;
    m_d_d       = (state_d == WR) ? data_d : '0;
    m_cima_d    = in_cim;
    m_start_d   = (state_d == START);
    m_xin_d     = in_cim ? xin_d : '0;
    m_inw_d     = in_cim ? inw_d : 1'b0;
    m_ww_d      = in_cim ? ww_d : 1'b0;
    res_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      row_q       <= '0;
      data_q      <= '0;
      xin_q       <= '0;
      inw_q       <= 1'b0;
      ww_q        <= 1'b0;
      cmd_ready_q <= 1'b0;
      m_d_q       <= '0;
      m_wa_q      <= '0;
      m_acm_en_q  <= 1'b0;
      m_cima_q    <= 1'b0;
      m_start_q   <= 1'b0;
      m_inw_q     <= 1'b0;
      m_ww_q      <= 1'b0;
      m_xin_q     <= '0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      res_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      row_q       <= row_d;
      data_q      <= data_d;
      xin_q       <= xin_d;
      inw_q       <= inw_d;
      ww_q        <= ww_d;
      cmd_ready_q <= cmd_ready_d;
      m_d_q       <= m_d_d;
      m_wa_q      <= m_wa_d;
      m_acm_en_q  <= 1'b1;
      m_cima_q    <= m_cima_d;
      m_start_q   <= m_start_d;
      m_inw_q     <= m_inw_d;
      m_ww_q      <= m_ww_d;
      m_xin_q     <= m_xin_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      res_err_q   <= res_err_d;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign m_D       = m_d_q;
  assign m_WA      = m_wa_q;
  assign m_acm_en  = m_acm_en_q;
  assign m_cima    = m_cima_q;
  assign m_start   = m_start_q;
  assign m_inwidth = m_inw_q;
  assign m_wwidth  = m_ww_q;
  assign m_xin0    = m_xin_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_data_q;
  assign res_err   = res_err_q;

endmodule

// File: tb/tb_dcim_macro_driver.sv
// Scoreboard bench for dcim_macro_driver with a reactive macro model (done flag driven N WAIT cycles after start).
module tb_dcim_macro_driver;

  localparam int unsigned TO = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic         cmd_op;
  logic [2:0]   cmd_row;
  logic [23:0]  cmd_data;
  logic [191:0] cmd_xin;
  logic         cmd_inwidth;
  logic         cmd_wwidth;
  logic [23:0]  m_D;
  logic [7:0]   m_WA;
  logic         m_acm_en;
  logic         m_cima;
  logic         m_start;
  logic         m_inwidth;
  logic         m_wwidth;
  logic [191:0] m_xin0;
  logic [50:0]  m_nout;
  logic         m_st;
  logic         res_valid;
  logic         res_ready;
  logic [50:0]  res_data;
  logic         res_err;

  int n_pass  = 0;
  int n_total = 0;

  typedef struct {
    logic [7:0]  wa;
    logic [23:0] d;
  } wr_exp_t;

  typedef struct {
    logic [50:0] data;
    logic        err;
    int          lat;
  } res_exp_t;

  wr_exp_t  wq[$];
  res_exp_t rq[$];

  always #5 clk = ~clk;

  dcim_macro_driver #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_row(cmd_row), .cmd_data(cmd_data), .cmd_xin(cmd_xin),
    .cmd_inwidth(cmd_inwidth), .cmd_wwidth(cmd_wwidth),
    .m_D(m_D), .m_WA(m_WA), .m_acm_en(m_acm_en), .m_cima(m_cima),
    .m_start(m_start), .m_inwidth(m_inwidth), .m_wwidth(m_wwidth),
    .m_xin0(m_xin0), .m_nout(m_nout), .m_st(m_st),
    .res_valid(res_valid), .res_ready(res_ready),
    .res_data(res_data), .res_err(res_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Present a command and return on the negedge just after its handshake edge
  task automatic send_cmd(input logic op, input logic [2:0] row, input logic [23:0] data,
                          input logic [191:0] xin, input logic iw, input logic ww);
    int guard = 0;
    cmd_valid = 1'b1; cmd_op = op; cmd_row = row; cmd_data = data;
    cmd_xin = xin; cmd_inwidth = iw; cmd_wwidth = ww;
    while (!cmd_ready && guard < 50) begin
      tick();
      guard++;
    end
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL cmd_accept: cmd_ready=%b want 1", cmd_ready);
    else n_pass++;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    logic [11:0] outs;
    rst = 1'b1;
    tick();
    tick();
    outs = {cmd_ready, m_acm_en, m_cima, m_start, m_inwidth, m_wwidth, res_valid, res_err,
            |m_WA, |m_D, |m_xin0, |res_data};
    n_total++;
    if (outs !== 12'h000) $display("FAIL reset_outputs: got %h want 000", outs);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL reset_release_ready: got %b want 1", cmd_ready);
    else n_pass++;
    n_total++;
    if (m_acm_en !== 1'b1) $display("FAIL reset_release_acm_en: got %b want 1", m_acm_en);
    else n_pass++;
  endtask

  task automatic test_write_b2b();
    int pulses = 0, last = -1, spacing_bad = 0, gaps_bad = 0, r = 0;
    bit hs;
    wr_exp_t e;
    logic [7:0] wa_e;
    cmd_valid = 1'b1; cmd_op = 1'b0; cmd_row = 3'd0; cmd_data = 24'd1;
    wq.push_back('{8'h01, 24'd1});
    for (int cyc = 0; cyc < 40; cyc++) begin
      hs = cmd_valid && cmd_ready;
      tick();
      if (hs) begin
        r++;
        if (r < 8) begin
          cmd_row = 3'(r);
          cmd_data = 24'(r + 1);
          wa_e = 8'h01 << r;
          wq.push_back('{wa_e, 24'(r + 1)});
        end else begin
          cmd_valid = 1'b0;
        end
      end
      if (m_WA !== 8'h00) begin
        pulses++;
        n_total++;
        if (wq.size() == 0) begin
          $display("FAIL wr_unexpected: m_WA=%h with no write pending", m_WA);
        end else begin
          n_pass++;
          e = wq.pop_front();
          n_total++;
          if (m_WA !== e.wa) $display("FAIL wr_addr: got %h want %h", m_WA, e.wa);
          else n_pass++;
          n_total++;
          if (m_D !== e.d) $display("FAIL wr_data: got %h want %h", m_D, e.d);
          else n_pass++;
        end
        if (m_cima !== 1'b0) gaps_bad++;
        if (last >= 0 && cyc - last != 3) spacing_bad++;
        last = cyc;
      end else if (m_D !== 24'h0) begin
        gaps_bad++;
      end
    end
    n_total++;
    if (pulses != 8) $display("FAIL wr_pulse_count: got %0d want 8", pulses);
    else n_pass++;
    n_total++;
    if (spacing_bad != 0) $display("FAIL wr_spacing: %0d pulses not 3 cycles apart, want 0", spacing_bad);
    else n_pass++;
    n_total++;
    if (gaps_bad != 0) $display("FAIL wr_gap_zero: %0d bad gap cycles, want 0", gaps_bad);
    else n_pass++;
  endtask

  // k = WAIT cycle (1-based) on which the model raises m_st; k = 0 means never
  task automatic test_compute(input int k, input logic [50:0] nout, input logic [191:0] xin,
                              input logic iw, input logic ww, input bit early, input int hold);
    res_exp_t e;
    int n = 1, starts = 0, st_at = -1, bad_drv = 0, unstable = 0;
    bit got = 0;
    logic [50:0] ed;
    logic eerr;
    int elat;
    logic [50:0] snap_d;
    logic snap_e;
    if (k == 0) begin ed = '0; eerr = 1'b1; elat = 3 + int'(TO); end
    else begin ed = nout; eerr = 1'b0; elat = 3 + k; end
    rq.push_back('{ed, eerr, elat});
    send_cmd(1'b1, 3'd0, 24'd0, xin, iw, ww);
    while (!got && n < 3 + int'(TO) + 10) begin
      if (m_start) begin starts++; st_at = n; end
      if (m_cima && (m_xin0 !== xin || m_inwidth !== iw || m_wwidth !== ww)) bad_drv++;
      if (res_valid) begin
        got = 1;
      end else begin
        m_st = 1'b0;
        m_nout = 51'h7_dead_beef;
        if (early && (st_at < 0 || st_at == n)) m_st = 1'b1;
        if (k != 0 && st_at >= 0 && n - st_at == k) begin m_st = 1'b1; m_nout = nout; end
        tick();
        n++;
      end
    end
    m_st = 1'b0;
    n_total++;
    if (!got) $display("FAIL res_timeout: no res_valid within %0d cycles", n);
    else n_pass++;
    if (got) begin
      n_total++;
      if (rq.size() == 0) begin
        $display("FAIL res_unexpected: result with empty scoreboard");
      end else begin
        n_pass++;
        e = rq.pop_front();
        n_total++;
        if (n != e.lat) $display("FAIL res_latency k=%0d: got %0d want %0d", k, n, e.lat);
        else n_pass++;
        n_total++;
        if (res_data !== e.data) $display("FAIL res_data k=%0d: got %h want %h", k, res_data, e.data);
        else n_pass++;
        n_total++;
        if (res_err !== e.err) $display("FAIL res_err k=%0d: got %b want %b", k, res_err, e.err);
        else n_pass++;
      end
    end
    n_total++;
    if (starts != 1) $display("FAIL start_pulses k=%0d: got %0d want 1", k, starts);
    else n_pass++;
    n_total++;
    if (bad_drv != 0) $display("FAIL xin_drive k=%0d: %0d bad cycles want 0", k, bad_drv);
    else n_pass++;
    snap_d = res_data;
    snap_e = res_err;
    cmd_valid = 1'b1; cmd_op = 1'b0;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (res_valid !== 1'b1 || res_data !== snap_d || res_err !== snap_e || cmd_ready !== 1'b0)
        unstable++;
    end
    cmd_valid = 1'b0;
    n_total++;
    if (unstable != 0) $display("FAIL resp_hold k=%0d: %0d unstable cycles want 0", k, unstable);
    else n_pass++;
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    n_total++;
    if (res_valid !== 1'b0 || m_cima !== 1'b0 || m_xin0 !== 192'h0)
      $display("FAIL resp_release k=%0d: res_valid=%b m_cima=%b want 0 0", k, res_valid, m_cima);
    else n_pass++;
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL ready_after_resp k=%0d: got %b want 1", k, cmd_ready);
    else n_pass++;
  endtask

  task automatic test_reset_in_wait();
    logic [11:0] outs;
    int stray = 0;
    wr_exp_t e;
    send_cmd(1'b1, 3'd0, 24'd0, {192{1'b1}}, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    n_total++;
    if (m_cima !== 1'b1 || m_start !== 1'b0) $display("FAIL pre_reset_wait: m_cima=%b m_start=%b want 1 0", m_cima, m_start);
    else n_pass++;
    rst = 1'b1;
    tick();
    outs = {cmd_ready, m_acm_en, m_cima, m_start, m_inwidth, m_wwidth, res_valid, res_err,
            |m_WA, |m_D, |m_xin0, |res_data};
    n_total++;
    if (outs !== 12'h000) $display("FAIL wait_reset_outputs: got %h want 000", outs);
    else n_pass++;
    rst = 1'b0;
    tick();
    n_total++;
    if (cmd_ready !== 1'b1) $display("FAIL wait_reset_ready: got %b want 1", cmd_ready);
    else n_pass++;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (res_valid || m_start || m_WA !== 8'h00) stray++;
    end
    n_total++;
    if (stray != 0) $display("FAIL wait_reset_abort: %0d stray cycles want 0", stray);
    else n_pass++;
    wq.push_back('{8'h20, 24'hABCDE});
    send_cmd(1'b0, 3'd5, 24'hABCDE, 192'h0, 1'b0, 1'b0);
    e = wq.pop_front();
    n_total++;
    if (m_WA !== e.wa || m_D !== e.d) $display("FAIL post_reset_write: got %h/%h want %h/%h", m_WA, m_D, e.wa, e.d);
    else n_pass++;
    tick();
    tick();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_op = 1'b0; cmd_row = '0; cmd_data = '0;
    cmd_xin = '0; cmd_inwidth = 1'b0; cmd_wwidth = 1'b0;
    m_nout = '0; m_st = 1'b0; res_ready = 1'b0;
    test_reset();
    test_write_b2b();
    test_compute(5, 51'h1234, {192{1'b1}}, 1'b0, 1'b0, 1'b0, 0);
    test_compute(0, 51'h55, {6{$urandom()}}, 1'b1, 1'b0, 1'b0, 0);
    test_compute(int'(TO), 51'h7_0000_0000_0001, {6{$urandom()}}, 1'b0, 1'b1, 1'b0, 10);
    test_compute(3, 51'h2_aaaa_5555_0f0f, {6{$urandom()}}, 1'b1, 1'b1, 1'b1, 2);
    test_compute(1, 51'h1, {6{$urandom()}}, 1'b0, 1'b0, 1'b0, 1);
    test_reset_in_wait();
    n_total++;
    if (rq.size() != 0 || wq.size() != 0) $display("FAIL scoreboard_drain: rq=%0d wq=%0d want 0 0", rq.size(), wq.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
